// File: rtl/dvi_tmds_transmitter_if.sv
// Pixel-side and serial-side signals of the DVI TMDS transmitter.
// The master drives pixels and watches the serial lines; the slave is the transmitter.
interface dvi_tmds_transmitter_if;
  logic       de;
  logic [7:0] blue, green, red;
  logic [1:0] ctrl0, ctrl1, ctrl2;
  logic       ch0, ch1, ch2, chc, pix_stb;

  modport master (output de, blue, ctrl0, green, ctrl1, red, ctrl2,
                  input  ch0, ch1, ch2, chc, pix_stb);
  modport slave  (input  de, blue, ctrl0, green, ctrl1, red, ctrl2,
                  output ch0, ch1, ch2, chc, pix_stb);
endinterface

// File: rtl/dvi_tmds_transmitter.sv
// DVI 1.0 TMDS transmitter: one 8b/10b encoder and serialiser per colour lane,
// plus a 10-cycle symbol framer and the TMDS clock-channel pattern.
module dvi_tmds_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       de,
  input  logic [7:0] d,
  input  logic [1:0] c,
  output logic       ser
);
  logic [9:0]        sh, q;
  logic [8:0]        q_m;
  logic signed [4:0] cnt, cnt_nxt, diff;

  // Transition minimisation; XNOR is XOR with an inverted chain.
  function automatic logic [8:0] stage1(input logic [7:0] v);
    logic [8:0] m;
    logic       xn;
    xn   = ($countones(v) > 4) || ($countones(v) == 4 && !v[0]);
    m[0] = v[0];
    for (int i = 1; i < 8; i++) m[i] = m[i-1] ^ v[i] ^ xn;
    m[8] = ~xn;
    return m;
  endfunction

  always_comb begin
    q_m     = stage1(d);
    diff    = 5'($countones(q_m[7:0]) * 2 - 8);  // n1q - n0q
    q       = '0;
    cnt_nxt = cnt;
    if (!de) begin
      case (c)
        2'b00:   q = 10'b1101010100;
        2'b01:   q = 10'b0010101011;
        2'b10:   q = 10'b0101010100;
        default: q = 10'b1010101011;
      endcase
      cnt_nxt = '0;
    end else if (cnt == 5'sd0 || diff == 5'sd0) begin
      q       = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_nxt = q_m[8] ? cnt + diff : cnt - diff;
    end else if ((cnt > 5'sd0 && diff > 5'sd0) || (cnt < 5'sd0 && diff < 5'sd0)) begin
      q       = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_nxt = cnt - diff + (q_m[8] ? 5'sd2 : 5'sd0);
    end else begin
      q       = {1'b0, q_m[8], q_m[7:0]};
      cnt_nxt = cnt + diff - (q_m[8] ? 5'sd0 : 5'sd2);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= q;
      cnt <= cnt_nxt;
    end else begin
      sh  <= sh >> 1;
    end
  end

  assign ser = sh[0];
endmodule

module dvi_tmds_transmitter (
  input  logic                   clk,
  input  logic                   rst,
  dvi_tmds_transmitter_if.slave  bus
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;

  logic [3:0]                          bit_cnt;
  logic                                boundary, stb_r, de_r;
  logic [NUM_LANES-1:0][VEC_W-1:0]     data_r;
  logic [NUM_LANES-1:0][1:0]           ctrl_r;
  logic [9:0]                          clk_sh;
  logic [NUM_LANES-1:0]                ser;

  assign boundary = (bit_cnt == 4'd9);

  // Reset parks the framer at bit 9 so the first edge after release loads a symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= 4'd9;
      stb_r   <= 1'b1;
      de_r    <= 1'b0;
      data_r  <= '0;
      ctrl_r  <= '0;
      clk_sh  <= '0;
    end else begin
      bit_cnt <= boundary ? 4'd0 : bit_cnt + 4'd1;
      stb_r   <= (bit_cnt == 4'd8);
      clk_sh  <= boundary ? 10'b0000011111 : clk_sh >> 1;
      if (boundary) begin
        de_r   <= bus.de;
        data_r <= {bus.red, bus.green, bus.blue};
        ctrl_r <= {bus.ctrl2, bus.ctrl1, bus.ctrl0};
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dvi_tmds_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (boundary),
      .de   (de_r),
      .d    (data_r[g]),
      .c    (ctrl_r[g]),
      .ser  (ser[g])
    );
  end

  assign bus.ch0     = ser[0];
  assign bus.ch1     = ser[1];
  assign bus.ch2     = ser[2];
  assign bus.chc     = clk_sh[0];
  assign bus.pix_stb = stb_r;
endmodule

// File: tb/tb_dvi_tmds_transmitter.sv
// Self-checking bench: random pixels against an integer-arithmetic TMDS model.
module tb_dvi_tmds_transmitter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dvi_tmds_transmitter_if bus();
  dvi_tmds_transmitter dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int mcnt[3];
  logic            pde;
  logic [2:0][7:0] pd;
  logic [2:0][1:0] pc;
  logic [2:0][9:0] got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pde = 1'b0;
    pd  = '0;
    pc  = '0;
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
  endtask

  task automatic model_enc(input int ln, input bit de_i, input logic [7:0] d,
                           input logic [1:0] c, output logic [9:0] q);
    logic [8:0] qm;
    int n1q, n0q;
    bit xn;
    if (!de_i) begin
      case (c)
        2'd0: q = 10'b1101010100;
        2'd1: q = 10'b0010101011;
        2'd2: q = 10'b0101010100;
        default: q = 10'b1010101011;
      endcase
      mcnt[ln] = 0;
      return;
    end
    xn = ($countones(d) > 4) || ($countones(d) == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (mcnt[ln] == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      mcnt[ln] += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((mcnt[ln] > 0 && n1q > n0q) || (mcnt[ln] < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      mcnt[ln] += (qm[8] ? 2 : 0) + (n0q - n1q);
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      mcnt[ln] += (qm[8] ? 0 : -2) + (n1q - n0q);
    end
  endtask

  // Called at the negedge just before a boundary edge; returns the symbols sent
  // during the following period (encoded from the previously captured pixel).
  task automatic run_pixel(input bit de_i, input logic [7:0] b, input logic [7:0] g,
                           input logic [7:0] r, input logic [1:0] c0, input logic [1:0] c1,
                           input logic [1:0] c2, output logic [2:0][9:0] sym);
    logic [2:0][9:0] exp;
    logic [9:0] gc, gs;
    chk("stb_pre", bus.pix_stb, 1);
    bus.de = de_i; bus.blue = b; bus.green = g; bus.red = r;
    bus.ctrl0 = c0; bus.ctrl1 = c1; bus.ctrl2 = c2;
    for (int ln = 0; ln < 3; ln++) model_enc(ln, pde, pd[ln], pc[ln], exp[ln]);
    pde = de_i; pd = {r, g, b}; pc = {c2, c1, c0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sym[0][i] = bus.ch0; sym[1][i] = bus.ch1; sym[2][i] = bus.ch2;
      gc[i] = bus.chc; gs[i] = bus.pix_stb;
      if (i == 4) begin
        bus.de = 1'($urandom); bus.blue = 8'($urandom); bus.green = 8'($urandom);
        bus.red = 8'($urandom); bus.ctrl0 = 2'($urandom); bus.ctrl1 = 2'($urandom);
        bus.ctrl2 = 2'($urandom);
      end
    end
    chk("ch0", sym[0], exp[0]);
    chk("ch1", sym[1], exp[1]);
    chk("ch2", sym[2], exp[2]);
    chk("chc", gc, 10'b0000011111);
    chk("pix_stb", gs, 10'b1000000000);
  endtask

  initial begin
    rst = 1'b0;
    bus.de = 1'b0; bus.blue = '0; bus.green = '0; bus.red = '0;
    bus.ctrl0 = '0; bus.ctrl1 = '0; bus.ctrl2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", {bus.ch0, bus.ch1, bus.ch2, bus.chc}, 0);
    chk("rst_stb", bus.pix_stb, 1);
    rst = 1'b1;
    model_reset();

    // control-00 idle
    for (int k = 0; k < 3; k++) begin
      run_pixel(0, 0, 0, 0, 0, 0, 0, got);
      chk("ctl00", got[0], 10'b1101010100);
    end
    // ctrl0 = 11 on blue only
    run_pixel(0, 0, 0, 0, 2'b11, 0, 0, got);
    run_pixel(0, 0, 0, 0, 0, 0, 0, got);
    chk("ctl11_ch0", got[0], 10'b1010101011);
    chk("ctl11_ch1", got[1], 10'b1101010100);
    chk("ctl11_ch2", got[2], 10'b1101010100);

    // active: blue 00 x3, green FF x2, then disparity clear through a control symbol
    run_pixel(1, 8'h00, 8'hFF, 8'($urandom), 0, 0, 0, got);
    run_pixel(1, 8'h00, 8'hFF, 8'($urandom), 0, 0, 0, got);
    chk("b00_1", got[0], 10'h100);
    chk("gff_1", got[1], 10'h200);
    run_pixel(1, 8'h00, 8'h55, 8'($urandom), 0, 0, 0, got);
    chk("b00_2", got[0], 10'h3FF);
    chk("gff_2", got[1], 10'h0FF);
    run_pixel(0, 0, 0, 0, 0, 0, 0, got);
    chk("b00_3", got[0], 10'h100);
    run_pixel(1, 8'h00, 8'($urandom), 8'($urandom), 0, 0, 0, got);
    chk("clr_ctl", got[0], 10'b1101010100);
    run_pixel(0, 0, 0, 0, 0, 0, 0, got);
    chk("clr_b00", got[0], 10'h100);

    // random traffic
    for (int k = 0; k < 200; k++)
      run_pixel($urandom_range(9) < 7, 8'($urandom), 8'($urandom), 8'($urandom),
                2'($urandom), 2'($urandom), 2'($urandom), got);

    // asynchronous reset in the middle of a symbol (bit_cnt == 4)
    bus.de = 1'b1; bus.blue = 8'($urandom);
    repeat (5) @(negedge clk);
    chk("pre_rst_chc", bus.chc, 1);
    rst = 1'b0;
    #1;
    chk("async_out", {bus.ch0, bus.ch1, bus.ch2, bus.chc}, 0);
    chk("async_stb", bus.pix_stb, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    run_pixel(1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, got);
    chk("rerst_ctl", got[0], 10'b1101010100);
    for (int k = 0; k < 10; k++)
      run_pixel($urandom_range(3) != 0, 8'($urandom), 8'($urandom), 8'($urandom),
                2'($urandom), 2'($urandom), 2'($urandom), got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
